// File: rtl/stream_framer_pkg.sv
// Shared types and helpers for the stream framer: byte width, FSM state
// encoding and the trailer checksum.
package stream_framer_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        PAYLOAD = 2'd0,
        TRAILER = 2'd1,
        DROP    = 2'd2
    } state_t;

    // Two's complement of the running sum: the trailer makes the whole frame
    // (payload bytes plus trailer) sum to zero modulo 256.
    function automatic logic [DATA_W-1:0] trailer_csum(input logic [DATA_W-1:0] sum);
        return (~sum) + DATA_W'(1);
    endfunction

endpackage

// File: rtl/stream_framer_if.sv
// Byte stream with valid/ready handshake and an end-of-frame marker.
// master drives valid/data/last, slave drives ready.
interface stream_framer_if;
    import stream_framer_pkg::*;

    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/stream_framer_out_reg.sv
// Single-entry output register carrying data+last. 'free' tells the framer
// that a new word may be loaded this cycle (empty, or draining now).
module stream_framer_out_reg
    import stream_framer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              free,
    stream_framer_if.master   m
);

    assign free = !m.valid || m.ready;

    // Hold the word until the downstream takes it; a load may overlap a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m.valid <= 1'b0;
            m.data  <= '0;
            m.last  <= 1'b0;
        end else if (load) begin
            m.valid <= 1'b1;
            m.data  <= load_data;
            m.last  <= load_last;
        end else if (m.ready) begin
            m.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_framer.sv
// Stream framer: passes payload bytes through and appends a checksum trailer
// byte (out_last=1) so each output frame sums to zero mod 256. Frames longer
// than MAX_LEN are cut at MAX_LEN, flagged with an err pulse, and the rest of
// the input frame is discarded.
// Optional build macro: STREAM_FRAMER_STATS_EN adds frame_count/err_count.
//
// state   | meaning
// PAYLOAD | forwarding payload bytes, accumulating sum and count
// TRAILER | waiting for the output register to emit the checksum byte
// DROP    | discarding the remainder of a truncated input frame
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int MAX_LEN = 64
)(
    input  logic            clk,
    input  logic            rst_n,
    stream_framer_if.slave  s_in,
    stream_framer_if.master s_out,
    output logic            err
`ifdef STREAM_FRAMER_STATS_EN
    ,
    output logic [15:0]     frame_count,
    output logic [7:0]      err_count
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sum, sum_nxt;
    logic [7:0]        count, count_nxt;
    logic              truncated, trunc_nxt;
    logic              err_nxt;
    logic              in_ready;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              free;

    assign s_in.ready = in_ready;

    // Next-state, handshake and datapath decisions for the framing FSM.
    always_comb begin
        state_nxt = state;
        sum_nxt   = sum;
        count_nxt = count;
        trunc_nxt = truncated;
        err_nxt   = 1'b0;
        in_ready  = 1'b0;
        load      = 1'b0;
        load_data = s_in.data;
        load_last = 1'b0;
        case (state)
            PAYLOAD: begin
                in_ready = free;
                if (s_in.valid && free) begin
                    load      = 1'b1;
                    sum_nxt   = sum + s_in.data;
                    count_nxt = count + 8'd1;
                    if (s_in.last) begin
                        state_nxt = TRAILER;
                    end else if (count == LAST_IDX) begin
                        // Overlong frame: close it here, discard the tail.
                        state_nxt = TRAILER;
                        trunc_nxt = 1'b1;
                        err_nxt   = 1'b1;
                    end
                end
            end
            TRAILER: begin
                if (free) begin
                    load      = 1'b1;
                    load_data = trailer_csum(sum);
                    load_last = 1'b1;
                    sum_nxt   = '0;
                    count_nxt = '0;
                    state_nxt = truncated ? DROP : PAYLOAD;
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (s_in.valid && s_in.last) begin
                    state_nxt = PAYLOAD;
                    trunc_nxt = 1'b0;
                end
            end
            default: state_nxt = PAYLOAD;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PAYLOAD;
        else        state <= state_nxt;
    end

    // Frame accumulators, truncation flag and registered err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            count     <= '0;
            truncated <= 1'b0;
            err       <= 1'b0;
        end else begin
            sum       <= sum_nxt;
            count     <= count_nxt;
            truncated <= trunc_nxt;
            err       <= err_nxt;
        end
    end

    stream_framer_out_reg u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .free      (free),
        .m         (s_out)
    );

`ifdef STREAM_FRAMER_STATS_EN
    // Frame counter wraps; error counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (s_out.valid && s_out.ready && s_out.last)
                frame_count <= frame_count + 16'd1;
            if (err && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
